// File: rtl/carrd_issue_if.sv
// Bus between the scalar pipeline / coprocessor and the CARRD issue unit.
// The issue unit takes the slave modport.
interface carrd_issue_if;
  logic        instr_valid;
  logic [31:0] instr_in;
  logic [31:0] rs1_in;
  logic        instr_ready;
  logic        illegal;
  logic [31:0] op_instr_base;
  logic [31:0] x_reg_data;
  logic        issue_valid;
  logic        v_done;
  logic        x_reg_wr_en;
  logic [31:0] x_wr_data;
  logic        x_rd_valid;
  logic [4:0]  x_rd_addr;
  logic [31:0] x_rd_data;
  logic        busy;
  logic        timeout_err;

  modport master (
    output instr_valid, instr_in, rs1_in, v_done, x_reg_wr_en, x_wr_data,
    input  instr_ready, illegal, op_instr_base, x_reg_data, issue_valid,
           x_rd_valid, x_rd_addr, x_rd_data, busy, timeout_err
  );

  modport slave (
    input  instr_valid, instr_in, rs1_in, v_done, x_reg_wr_en, x_wr_data,
    output instr_ready, illegal, op_instr_base, x_reg_data, issue_valid,
           x_rd_valid, x_rd_addr, x_rd_data, busy, timeout_err
  );
endinterface

// File: rtl/carrd_issue.sv
// CARRD issue unit: buffers OP-V instructions in a FIFO, presents one at a time
// to the vector coprocessor and returns scalar results to the base core.
module carrd_issue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          nrst,
  carrd_issue_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [6:0] OPCODE_OPV = 7'b1010111;
  localparam logic [2:0] FUNCT3_CFG = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  function automatic logic is_opv(input logic [31:0] instr);
    return instr[6:0] == OPCODE_OPV;
  endfunction

  state_t        state_r, state_s;
  logic [31:0]   instr_mem_r [DEPTH];
  logic [31:0]   rs1_mem_r   [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [TW-1:0] tcnt_r;
  logic [31:0]   cur_instr_r, cur_rs1_r;
  logic          illegal_r, x_rd_valid_r, timeout_err_r;
  logic [4:0]    x_rd_addr_r;
  logic [31:0]   x_rd_data_r;
  logic          full_s, empty_s, push_s, pop_s, abort_s, x_wr_s;

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});
  assign push_s  = bus.instr_valid && !full_s && is_opv(bus.instr_in);
  assign x_wr_s  = bus.x_reg_wr_en && (state_r != IDLE);

  // Next-state logic; pop only from IDLE so a freed slot is not reused the same cycle
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    abort_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (cur_instr_r[14:12] == FUNCT3_CFG) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      WAIT: begin
        // v_done on the last allowed cycle still completes the instruction
        if (bus.v_done) begin
          state_s = IDLE;
        end else if (tcnt_r == TW'(TIMEOUT)) begin
          abort_s = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem_r[wr_ptr_r] <= bus.instr_in;
      rs1_mem_r[wr_ptr_r]   <= bus.rs1_in;
    end
  end

  // State, in-flight instruction and WAIT cycle counter (k-th WAIT cycle holds k)
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r     <= IDLE;
      cur_instr_r <= 32'h0;
      cur_rs1_r   <= 32'h0;
      tcnt_r      <= {TW{1'b0}};
    end else begin
      state_r <= state_s;
      if (pop_s) begin
        cur_instr_r <= instr_mem_r[rd_ptr_r];
        cur_rs1_r   <= rs1_mem_r[rd_ptr_r];
      end
      if (state_s == WAIT) begin
        tcnt_r <= (state_r == WAIT) ? tcnt_r + TW'(1) : TW'(1);
      end else begin
        tcnt_r <= {TW{1'b0}};
      end
    end
  end

  // Registered status and scalar-return outputs
  always_ff @(posedge clk) begin
    if (!nrst) begin
      illegal_r     <= 1'b0;
      x_rd_valid_r  <= 1'b0;
      x_rd_addr_r   <= 5'd0;
      x_rd_data_r   <= 32'h0;
      timeout_err_r <= 1'b0;
    end else begin
      illegal_r    <= bus.instr_valid && !is_opv(bus.instr_in);
      x_rd_valid_r <= x_wr_s;
      if (x_wr_s) begin
        x_rd_addr_r <= cur_instr_r[11:7];
        x_rd_data_r <= bus.x_wr_data;
      end
      if (abort_s) timeout_err_r <= 1'b1;
    end
  end

  assign bus.instr_ready   = !full_s;
  assign bus.illegal       = illegal_r;
  assign bus.issue_valid   = (state_r == ISSUE);
  assign bus.op_instr_base = (state_r != IDLE) ? cur_instr_r : 32'h0;
  assign bus.x_reg_data    = (state_r != IDLE) ? cur_rs1_r : 32'h0;
  assign bus.x_rd_valid    = x_rd_valid_r;
  assign bus.x_rd_addr     = x_rd_addr_r;
  assign bus.x_rd_data     = x_rd_data_r;
  assign bus.busy          = !empty_s || (state_r != IDLE);
  assign bus.timeout_err   = timeout_err_r;
endmodule
